// File: rtl/dmem_pkg.sv
// dmem_pkg
//   Shared types for the data-memory scheduler: top-level FSM states,
//   lock-owner encoding, and a helper that turns an address width into
//   a memory depth.
package dmem_pkg;

  typedef enum logic {CLEAR, ARB} dmem_state_t;

  typedef enum logic [1:0] {
    OWN_R0   = 2'd0,
    OWN_R1   = 2'd1,
    OWN_NONE = 2'd2
  } dmem_owner_t;

  function automatic int dmem_depth(input int aw);
    return 1 << aw;
  endfunction

endpackage

// File: rtl/dmem_scheduler_rr_arb2.sv
// rr_arb2
//   Two-way round-robin arbiter with a bounded lock. A requester granted
//   with its Lock bit set keeps the port on following cycles, while it
//   keeps requesting, for up to MAX_LOCK consecutive grants. After that
//   the lock is broken and plain round-robin decides again.
// Ports
//   Clk, Reset_n  clock, asynchronous active-low reset
//   En            arbitration allowed this cycle (state ARB, no Init)
//   Clr           drop any lock (Init accepted)
//   Req[1:0]      requests from R0 (bit 0) and R1 (bit 1)
//   Lock[1:0]     keep-grant request, meaningful only with Req
//   Gnt[1:0]      combinational grant, one-hot or zero
module rr_arb2
  import dmem_pkg::*;
#(
  parameter int MAX_LOCK = 4
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       En,
  input  logic       Clr,
  input  logic [1:0] Req,
  input  logic [1:0] Lock,
  output logic [1:0] Gnt
);

  localparam int            CW      = $clog2(MAX_LOCK + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_LOCK);

  logic          ptr;       // requester preferred on contention (0 = R0)
  dmem_owner_t   owner;
  logic [CW-1:0] lock_cnt;  // consecutive locked grants held by owner

  logic owner_req;
  logic hold;
  logic gidx;
  logic same_owner;
  logic keep_lock;

  always_comb begin
    owner_req  = 1'b0;
    if (owner == OWN_R0) owner_req = Req[0];
    if (owner == OWN_R1) owner_req = Req[1];
    hold       = owner_req && (lock_cnt < CNT_MAX);

    Gnt = 2'b00;
    if (En) begin
      if (hold)
        Gnt = (owner == OWN_R1) ? 2'b10 : 2'b01;
      else if (&Req)
        Gnt = ptr ? 2'b10 : 2'b01;
      else
        Gnt = Req;
    end

    gidx       = Gnt[1];
    same_owner = gidx ? (owner == OWN_R1) : (owner == OWN_R0);
    // An exhausted owner may not re-lock on the very grant that breaks it;
    // the other requester may start a fresh lock at any time.
    keep_lock  = Lock[gidx] && !(same_owner && (lock_cnt >= CNT_MAX));
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      ptr      <= 1'b0;
      owner    <= OWN_NONE;
      lock_cnt <= '0;
    end else if (Clr) begin
      owner    <= OWN_NONE;
      lock_cnt <= '0;
    end else if (|Gnt) begin
      ptr <= ~gidx;
      if (keep_lock) begin
        owner    <= gidx ? OWN_R1 : OWN_R0;
        lock_cnt <= same_owner ? lock_cnt + CW'(1) : CW'(1);
      end else begin
        owner    <= OWN_NONE;
        lock_cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/dmem_scheduler.sv
// dmem_scheduler
//   Owns the single port of the data memory. After reset, or on Init, it
//   writes zero to every word (CLEAR), then shares the port between R0
//   (core) and R1 (DMA) through rr_arb2 (ARB). Accesses are zero-latency:
//   read data is the memory's combinational output in the grant cycle.
// Ports
//   Clk, Reset_n            clock, asynchronous active-low reset
//   Init                    request full re-clear (sampled in ARB)
//   InitBusy                high while clearing or in reset
//   Req*/We*/Lock*/Addr*/Wd* requester inputs
//   Gnt*/Rd*                grant and read data back to requesters
//   MemWe/MemAddr/MemWd     memory port drive
//   MemRd                   memory combinational read data
module dmem_scheduler
  import dmem_pkg::*;
#(
  parameter int W        = 8,
  parameter int A        = 8,
  parameter int MAX_LOCK = 4
) (
  input  logic         Clk,
  input  logic         Reset_n,
  input  logic         Init,
  output logic         InitBusy,
  input  logic         Req0,
  input  logic         Req1,
  input  logic         We0,
  input  logic         We1,
  input  logic         Lock0,
  input  logic         Lock1,
  input  logic [A-1:0] Addr0,
  input  logic [A-1:0] Addr1,
  input  logic [W-1:0] Wd0,
  input  logic [W-1:0] Wd1,
  output logic         Gnt0,
  output logic         Gnt1,
  output logic [W-1:0] Rd0,
  output logic [W-1:0] Rd1,
  output logic         MemWe,
  output logic [A-1:0] MemAddr,
  output logic [W-1:0] MemWd,
  input  logic [W-1:0] MemRd
);

  localparam int         DEPTH    = dmem_depth(A);
  localparam logic [A:0] CLR_LAST = (A+1)'(DEPTH - 1);

  dmem_state_t state, state_nxt;
  logic [A:0]  clr_addr, clr_addr_nxt;  // extra bit avoids wrap ambiguity

  logic        arb_en;
  logic        arb_clr;
  logic [1:0]  gnt;
  logic        we_c;
  logic        busy_c;
  logic [W-1:0] rd0_c;
  logic [W-1:0] rd1_c;

  assign arb_en  = (state == ARB) && !Init;
  assign arb_clr = (state == ARB) &&  Init;

  rr_arb2 #(
    .MAX_LOCK (MAX_LOCK)
  ) u_arb (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .En      (arb_en),
    .Clr     (arb_clr),
    .Req     ({Req1, Req0}),
    .Lock    ({Lock1 & Req1, Lock0 & Req0}),
    .Gnt     (gnt)
  );

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state    <= CLEAR;
      clr_addr <= '0;
    end else begin
      state    <= state_nxt;
      clr_addr <= clr_addr_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    clr_addr_nxt = clr_addr;
    busy_c       = 1'b0;
    we_c         = 1'b0;
    MemAddr      = '0;
    MemWd        = '0;
    rd0_c        = '0;
    rd1_c        = '0;

    unique case (state)
      CLEAR: begin
        busy_c  = 1'b1;
        we_c    = 1'b1;
        MemAddr = clr_addr[A-1:0];
        if (clr_addr == CLR_LAST) begin
          state_nxt    = ARB;
          clr_addr_nxt = '0;
        end else begin
          clr_addr_nxt = clr_addr + (A+1)'(1);
        end
      end
      ARB: begin
        if (Init) begin
          state_nxt    = CLEAR;
          clr_addr_nxt = '0;
        end else if (gnt[0]) begin
          we_c    = We0;
          MemAddr = Addr0;
          MemWd   = Wd0;
          rd0_c   = MemRd;
        end else if (gnt[1]) begin
          we_c    = We1;
          MemAddr = Addr1;
          MemWd   = Wd1;
          rd1_c   = MemRd;
        end
      end
      default: ;
    endcase
  end

  // Reset gates the memory strobe and requester outputs without waiting
  // for a clock edge.
  assign MemWe    = we_c & Reset_n;
  assign Gnt0     = gnt[0] & Reset_n;
  assign Gnt1     = gnt[1] & Reset_n;
  assign Rd0      = rd0_c & {W{Reset_n}};
  assign Rd1      = rd1_c & {W{Reset_n}};
  assign InitBusy = busy_c | ~Reset_n;

endmodule

// File: tb/tb_dmem_scheduler.sv
module tb_dmem_scheduler;

  localparam int W = 8;
  localparam int A = 8;
  localparam int ML = 4;
  localparam int DEPTH = 256;

  logic         Clk = 1'b0;
  logic         Reset_n = 1'b0;
  logic         Init = 1'b0;
  logic         InitBusy;
  logic         Req0 = 1'b0, Req1 = 1'b0, We0 = 1'b0, We1 = 1'b0;
  logic         Lock0 = 1'b0, Lock1 = 1'b0;
  logic [A-1:0] Addr0 = '0, Addr1 = '0;
  logic [W-1:0] Wd0 = '0, Wd1 = '0;
  logic         Gnt0, Gnt1;
  logic [W-1:0] Rd0, Rd1;
  logic         MemWe;
  logic [A-1:0] MemAddr;
  logic [W-1:0] MemWd;
  logic [W-1:0] MemRd;

  dmem_scheduler #(.W(W), .A(A), .MAX_LOCK(ML)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .Init(Init), .InitBusy(InitBusy),
    .Req0(Req0), .Req1(Req1), .We0(We0), .We1(We1),
    .Lock0(Lock0), .Lock1(Lock1), .Addr0(Addr0), .Addr1(Addr1),
    .Wd0(Wd0), .Wd1(Wd1), .Gnt0(Gnt0), .Gnt1(Gnt1), .Rd0(Rd0), .Rd1(Rd1),
    .MemWe(MemWe), .MemAddr(MemAddr), .MemWd(MemWd), .MemRd(MemRd)
  );

  always #5 Clk = ~Clk;

  // External memory: combinational read, write at clock edge.
  logic         prefill = 1'b1;
  logic [W-1:0] mem [DEPTH];
  assign MemRd = mem[MemAddr];
  always @(posedge Clk) begin
    if (prefill) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= 8'h5A ^ 8'(i) | 8'h01;
    end else if (MemWe) begin
      mem[MemAddr] <= MemWd;
    end
  end

  // Reference model state
  int           n_chk = 0, n_err = 0;
  bit           m_clear;
  int           m_clr, m_ptr, m_owner, m_cnt;
  logic [W-1:0] ref_mem [DEPTH];
  int           obs_g;
  logic [W-1:0] obs_rd0, obs_rd1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_clear = 1'b1; m_clr = 0; m_ptr = 0; m_owner = -1; m_cnt = 0;
  endtask

  // One clock cycle: check outputs mid-cycle against the model, then
  // advance the model at the edge.
  task automatic step();
    logic         rq[2], wq[2], lq[2];
    logic [A-1:0] aq[2];
    logic [W-1:0] dq[2];
    int           g;
    logic         e_we;
    logic [A-1:0] e_addr;
    logic [W-1:0] e_wd, e_rd0, e_rd1;
    @(negedge Clk);
    rq[0] = Req0; rq[1] = Req1; wq[0] = We0; wq[1] = We1;
    lq[0] = Lock0 & Req0; lq[1] = Lock1 & Req1;
    aq[0] = Addr0; aq[1] = Addr1; dq[0] = Wd0; dq[1] = Wd1;
    g = -1; e_we = 0; e_addr = '0; e_wd = '0; e_rd0 = '0; e_rd1 = '0;
    if (m_clear) begin
      e_we = 1; e_addr = A'(m_clr);
    end else if (!Init) begin
      if (m_owner >= 0 && rq[m_owner] && m_cnt < ML) g = m_owner;
      else if (rq[0] && rq[1]) g = m_ptr;
      else if (rq[0]) g = 0;
      else if (rq[1]) g = 1;
      if (g >= 0) begin
        e_we = wq[g]; e_addr = aq[g]; e_wd = dq[g];
        if (g == 0) e_rd0 = ref_mem[aq[g]]; else e_rd1 = ref_mem[aq[g]];
      end
    end
    chk("busy", InitBusy, m_clear);
    chk("gnt0", Gnt0, g == 0);
    chk("gnt1", Gnt1, g == 1);
    chk("memwe", MemWe, e_we);
    chk("memaddr", MemAddr, e_addr);
    chk("memwd", MemWd, e_wd);
    chk("rd0", Rd0, e_rd0);
    chk("rd1", Rd1, e_rd1);
    obs_g = Gnt1 ? 1 : (Gnt0 ? 0 : -1);
    obs_rd0 = Rd0; obs_rd1 = Rd1;
    @(posedge Clk);
    if (m_clear) begin
      ref_mem[m_clr] = '0;
      if (m_clr == DEPTH - 1) begin m_clear = 0; m_clr = 0; end
      else m_clr++;
    end else if (Init) begin
      m_clear = 1; m_clr = 0; m_owner = -1; m_cnt = 0;
    end else if (g >= 0) begin
      if (wq[g]) ref_mem[aq[g]] = dq[g];
      m_ptr = 1 - g;
      // A requester keeps the port for at most ML consecutive locked grants.
      if (lq[g] && !(m_owner == g && m_cnt >= ML)) begin
        m_cnt = (m_owner == g) ? m_cnt + 1 : 1;
        m_owner = g;
      end else begin
        m_owner = -1; m_cnt = 0;
      end
    end
    #1;
  endtask

  task automatic idle();
    Req0 = 0; Req1 = 0; We0 = 0; We1 = 0; Lock0 = 0; Lock1 = 0; Init = 0;
  endtask

  task automatic run_clear();
    int guard;
    guard = 0;
    while (m_clear && guard < 400) begin step(); guard++; end
    chk("clear_done", m_clear, 1'b0);
  endtask

  int pat_rr [6] = '{0, 1, 0, 1, 0, 1};
  int pat_lk [9] = '{1, 1, 1, 1, 0, 1, 1, 1, 1};

  initial begin
    model_reset();
    repeat (2) @(posedge Clk);
    #1;
    prefill = 1'b0;
    chk("rst_memwe", MemWe, 1'b0);
    chk("rst_busy", InitBusy, 1'b1);
    chk("rst_gnt", {Gnt1, Gnt0}, 2'b00);
    Reset_n = 1'b1;

    // Full clear after reset release
    run_clear();

    // Single requester write then read back through the other port
    Req0 = 1; We0 = 1; Addr0 = 8'h10; Wd0 = 8'hA5;
    step();
    chk("single_w_gnt", obs_g, 0);
    idle(); Req1 = 1; Addr1 = 8'h10;
    step();
    chk("single_rd", obs_rd1, 8'hA5);

    // Contention from Ptr=R0
    idle(); Req0 = 1; Req1 = 1; Addr0 = 8'h10; Addr1 = 8'h11;
    for (int i = 0; i < 6; i++) begin
      step();
      chk("rr_pat", obs_g, pat_rr[i]);
    end

    // Lock by R1; one R0 access first so R1 is preferred
    idle(); Req0 = 1;
    step();
    Req1 = 1; Lock1 = 1;
    for (int i = 0; i < 9; i++) begin
      step();
      chk("lock_pat", obs_g, pat_lk[i]);
    end

    // Init while R0 requests
    idle(); Req0 = 1; Addr0 = 8'h10; Init = 1;
    step();
    chk("init_nogrant", obs_g, -1);
    Init = 0;
    run_clear();
    idle(); Req1 = 1; Addr1 = 8'h10;
    step();
    chk("init_cleared", obs_rd1, 8'h00);

    // Randomized traffic with occasional Init
    for (int i = 0; i < 1500; i++) begin
      Req0 = 1'($urandom); Req1 = 1'($urandom);
      We0 = 1'($urandom); We1 = 1'($urandom);
      Lock0 = Req0 & 1'($urandom); Lock1 = Req1 & 1'($urandom);
      Addr0 = A'($urandom_range(0, 15)); Addr1 = A'($urandom_range(0, 15));
      Wd0 = W'($urandom); Wd1 = W'($urandom);
      Init = ($urandom_range(0, 299) == 0);
      step();
    end
    idle();
    run_clear();

    // Reset asserted mid-clear at ClrAddr 0x80
    Init = 1;
    step();
    Init = 0;
    for (int i = 0; i < 300 && m_clr != 'h80; i++) step();
    chk("mid_addr", MemAddr, 8'h80);
    Reset_n = 1'b0;
    #1;
    chk("mid_memwe", MemWe, 1'b0);
    chk("mid_busy", InitBusy, 1'b1);
    chk("mid_addr0", MemAddr, 8'h00);
    repeat (2) @(posedge Clk);
    #1;
    Reset_n = 1'b1;
    model_reset();
    run_clear();
    Req0 = 1; Addr0 = 8'h10;
    step();
    chk("post_rst_rd", obs_rd0, 8'h00);
    idle();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout t=%0t", $time);
    $fatal(1, "timeout");
  end

endmodule
